// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the RV32IM 5-stage core. It combines branch redirect,
// a multi-cycle load-use stall, a per-register scoreboard for div/rem results
// and a cap on in-flight long-latency operations. It drives the PC, IF/ID and
// ID/EX enables and flushes.
module hazard_scoreboard_unit #(
  parameter int LOAD_STALL   = 1,
  parameter int MAX_INFLIGHT = 1,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_PCSrc,
  input  logic             i_MemRead_E,
  input  logic [4:0]       i_rd_E,
  input  logic [4:0]       i_rs1_D,
  input  logic [4:0]       i_rs2_D,
  input  logic             i_rs1_used_D,
  input  logic             i_rs2_used_D,
  input  logic [4:0]       i_rd_D,
  input  logic             i_RegWrite_D,
  input  logic             i_is_long_D,
  input  logic             i_lat_wb_valid,
  input  logic [4:0]       i_lat_wb_rd,
  output logic             o_PC_Write,
  output logic             o_IFID_Write,
  output logic             o_IFID_Flush,
  output logic             o_IDEX_Flush,
  output logic [CNT_W-1:0] o_inflight_cnt,
  output logic [31:0]      o_busy_vec,
  output logic             o_sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [2:0]       LD_INIT = 3'(LOAD_STALL - 1);

  logic [2:0]       r_ldCnt;
  logic [CNT_W-1:0] r_inflightCnt;
  logic [31:0]      r_busy;
  logic             r_sbErr;

  logic             w_newLoadHaz;
  logic             w_loadStall;
  logic             w_sbStall;
  logic             w_structStall;
  logic             w_stall;
  logic             w_issue;
  logic             w_wbLegal;
  logic [31:0]      w_busyNext;
  logic [CNT_W-1:0] w_cntNext;

  // Hazard classification; the scoreboard deliberately reads registered busy
  // bits, so a same-cycle completion still stalls for one conservative cycle.
  always_comb begin
    w_newLoadHaz  = i_MemRead_E && (i_rd_E != 5'd0) &&
                    ((i_rs1_used_D && (i_rs1_D == i_rd_E)) ||
                     (i_rs2_used_D && (i_rs2_D == i_rd_E)));
    w_loadStall   = (r_ldCnt != 3'd0) || w_newLoadHaz;
    w_sbStall     = (i_rs1_used_D && r_busy[i_rs1_D]) ||
                    (i_rs2_used_D && r_busy[i_rs2_D]) ||
                    (i_RegWrite_D && r_busy[i_rd_D]);
    w_structStall = i_is_long_D && (r_inflightCnt == MAX_CNT);
    w_stall       = w_loadStall || w_sbStall || w_structStall;
    w_issue       = i_is_long_D && !i_PCSrc && !w_stall;
    w_wbLegal     = i_lat_wb_valid && (r_inflightCnt != '0);
  end

  // Pipeline control: reset forces free-running, branch redirect outranks stalls.
  always_comb begin
    o_PC_Write   = 1'b1;
    o_IFID_Write = 1'b1;
    o_IFID_Flush = 1'b0;
    o_IDEX_Flush = 1'b0;
    if (i_rst) begin
      o_PC_Write   = 1'b1;
    end else if (i_PCSrc) begin
      o_IFID_Flush = 1'b1;
      o_IDEX_Flush = 1'b1;
    end else if (w_stall) begin
      o_PC_Write   = 1'b0;
      o_IFID_Write = 1'b0;
      o_IDEX_Flush = 1'b1;
    end
  end

  // Next scoreboard: completion clears first so an issue to the same register wins.
  always_comb begin
    w_busyNext = r_busy;
    if (w_wbLegal) begin
      w_busyNext[i_lat_wb_rd] = 1'b0;
    end
    if (w_issue && i_RegWrite_D && (i_rd_D != 5'd0)) begin
      w_busyNext[i_rd_D] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  // Next in-flight count: issue and legal completion together cancel out.
  always_comb begin
    w_cntNext = r_inflightCnt;
    unique case ({w_issue, w_wbLegal})
      2'b10: if (r_inflightCnt != MAX_CNT) w_cntNext = r_inflightCnt + CNT_W'(1);
      2'b01: w_cntNext = r_inflightCnt - CNT_W'(1);
      default: w_cntNext = r_inflightCnt;
    endcase
  end

  // State update: load-stall countdown, scoreboard, counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ldCnt       <= 3'd0;
      r_inflightCnt <= '0;
      r_busy        <= 32'd0;
      r_sbErr       <= 1'b0;
    end else begin
      if (i_PCSrc) begin
        r_ldCnt <= 3'd0;
      end else if (r_ldCnt != 3'd0) begin
        r_ldCnt <= r_ldCnt - 3'd1;
      end else if (w_newLoadHaz) begin
        r_ldCnt <= LD_INIT;
      end
      r_inflightCnt <= w_cntNext;
      r_busy        <= w_busyNext;
      if (i_lat_wb_valid && (r_inflightCnt == '0)) begin
        r_sbErr <= 1'b1;
      end
    end
  end

  assign o_inflight_cnt = r_inflightCnt;
  assign o_busy_vec     = r_busy;
  assign o_sb_err       = r_sbErr;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit. Two instances share every input: dutA uses
// a 2-cycle load stall, dutB a 3-cycle one, both allow one long op in flight.
module tb_hazard_scoreboard_unit;

  localparam logic [3:0] RUN = 4'b1100;
  localparam logic [3:0] STL = 4'b0001;
  localparam logic [3:0] BR  = 4'b1111;

  typedef struct {
    string       name;
    logic [3:0]  ctrlA;
    logic [3:0]  ctrlB;
    int          cnt;
    logic [31:0] busy;
    logic        err;
  } expItem;

  logic        clk;
  logic        rst;
  logic        pcSrc, memReadE, rs1Used, rs2Used, regWriteD, isLongD, wbValid;
  logic [4:0]  rdE, rs1D, rs2D, rdD, wbRd;
  logic        pcwA, ifidwA, ifidfA, idexfA, errA;
  logic        pcwB, ifidwB, ifidfB, idexfB, errB;
  logic [0:0]  cntA, cntB;
  logic [31:0] busyA, busyB;

  expItem expQ[$];
  int     nChecks = 0;
  int     nFails  = 0;

  hazard_scoreboard_unit #(.LOAD_STALL(2), .MAX_INFLIGHT(1)) dutA (
    .i_clk(clk), .i_rst(rst), .i_PCSrc(pcSrc), .i_MemRead_E(memReadE), .i_rd_E(rdE),
    .i_rs1_D(rs1D), .i_rs2_D(rs2D), .i_rs1_used_D(rs1Used), .i_rs2_used_D(rs2Used),
    .i_rd_D(rdD), .i_RegWrite_D(regWriteD), .i_is_long_D(isLongD),
    .i_lat_wb_valid(wbValid), .i_lat_wb_rd(wbRd),
    .o_PC_Write(pcwA), .o_IFID_Write(ifidwA), .o_IFID_Flush(ifidfA), .o_IDEX_Flush(idexfA),
    .o_inflight_cnt(cntA), .o_busy_vec(busyA), .o_sb_err(errA)
  );

  hazard_scoreboard_unit #(.LOAD_STALL(3), .MAX_INFLIGHT(1)) dutB (
    .i_clk(clk), .i_rst(rst), .i_PCSrc(pcSrc), .i_MemRead_E(memReadE), .i_rd_E(rdE),
    .i_rs1_D(rs1D), .i_rs2_D(rs2D), .i_rs1_used_D(rs1Used), .i_rs2_used_D(rs2Used),
    .i_rd_D(rdD), .i_RegWrite_D(regWriteD), .i_is_long_D(isLongD),
    .i_lat_wb_valid(wbValid), .i_lat_wb_rd(wbRd),
    .o_PC_Write(pcwB), .o_IFID_Write(ifidwB), .o_IFID_Flush(ifidfB), .o_IDEX_Flush(idexfB),
    .o_inflight_cnt(cntB), .o_busy_vec(busyB), .o_sb_err(errB)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue what the
  // outputs must show before the next rising edge.
  task automatic applyStimulus(input string name, input logic r, input logic pcs,
                               input logic mr, input logic [4:0] re,
                               input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] rd, input logic rw, input logic il,
                               input logic wv, input logic [4:0] wr,
                               input logic [3:0] eA, input logic [3:0] eB,
                               input int eCnt, input logic [31:0] eBusy, input logic eErr);
    expItem item;
    @(posedge clk);
    #1;
    rst = r; pcSrc = pcs; memReadE = mr; rdE = re;
    rs1D = r1; rs1Used = u1; rs2D = r2; rs2Used = u2;
    rdD = rd; regWriteD = rw; isLongD = il; wbValid = wv; wbRd = wr;
    item.name = name; item.ctrlA = eA; item.ctrlB = eB;
    item.cnt = eCnt; item.busy = eBusy; item.err = eErr;
    expQ.push_back(item);
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input expItem e);
    cmp(e.name, "ctrlA", 32'({pcwA, ifidwA, ifidfA, idexfA}), 32'(e.ctrlA));
    cmp(e.name, "ctrlB", 32'({pcwB, ifidwB, ifidfB, idexfB}), 32'(e.ctrlB));
    cmp(e.name, "cntA", 32'(cntA), 32'(e.cnt));
    cmp(e.name, "cntB", 32'(cntB), 32'(e.cnt));
    cmp(e.name, "busyA", busyA, e.busy);
    cmp(e.name, "busyB", busyB, e.busy);
    cmp(e.name, "errA", 32'(errA), 32'(e.err));
    cmp(e.name, "errB", 32'(errB), 32'(e.err));
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  // Directed sequence; each line is one cycle with hand-derived outputs.
  initial begin
    rst = 1'b1; pcSrc = 0; memReadE = 0; rdE = 0; rs1D = 0; rs1Used = 0;
    rs2D = 0; rs2Used = 0; rdD = 0; regWriteD = 0; isLongD = 0; wbValid = 0; wbRd = 0;
    //            name              rst pcs mr rdE r1 u1 r2 u2 rdD rw il wv wr  A    B   cnt busy      err
    applyStimulus("reset_state",     1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("idle",            0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("ld_detect",       0, 0, 1, 5,  5, 1, 0, 0, 0,  0, 0, 0, 0, STL, STL, 0, 32'h0,   0);
    applyStimulus("ld_stall2",       0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, STL, STL, 0, 32'h0,   0);
    applyStimulus("ld_a_done",       0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, RUN, STL, 0, 32'h0,   0);
    applyStimulus("ld_b_done",       0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("ld_rs2_detect",   0, 0, 1, 12, 0, 0, 12,1, 0,  0, 0, 0, 0, STL, STL, 0, 32'h0,   0);
    applyStimulus("ld_rs2_stall2",   0, 0, 0, 0,  0, 0, 12,1, 0,  0, 0, 0, 0, STL, STL, 0, 32'h0,   0);
    applyStimulus("ld_rs2_a_done",   0, 0, 0, 0,  0, 0, 12,1, 0,  0, 0, 0, 0, RUN, STL, 0, 32'h0,   0);
    applyStimulus("ld_unused_src",   0, 0, 1, 5,  5, 0, 5, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("br_ld_detect",    0, 0, 1, 5,  5, 1, 0, 0, 0,  0, 0, 0, 0, STL, STL, 0, 32'h0,   0);
    applyStimulus("br_in_stall",     0, 1, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, BR,  BR,  0, 32'h0,   0);
    applyStimulus("br_after",        0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("x0_load",         0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("x0_div",          0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("x0_after",        0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 1, 32'h0,   0);
    applyStimulus("x0_wb",           0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, RUN, RUN, 1, 32'h0,   0);
    applyStimulus("x0_clear",        0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("div_x7",          0, 0, 0, 0,  0, 0, 0, 0, 7,  1, 1, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("raw_x7",          0, 0, 0, 0,  7, 1, 0, 0, 8,  1, 0, 0, 0, STL, STL, 1, 32'h80,  0);
    applyStimulus("raw_x7_wb",       0, 0, 0, 0,  7, 1, 0, 0, 8,  1, 0, 1, 7, STL, STL, 1, 32'h80,  0);
    applyStimulus("raw_x7_go",       0, 0, 0, 0,  7, 1, 0, 0, 8,  1, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("div_x3",          0, 0, 0, 0,  0, 0, 0, 0, 3,  1, 1, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("struct_x4",       0, 0, 0, 0,  0, 0, 0, 0, 4,  1, 1, 0, 0, STL, STL, 1, 32'h8,   0);
    applyStimulus("struct_x4_wb3",   0, 0, 0, 0,  0, 0, 0, 0, 4,  1, 1, 1, 3, STL, STL, 1, 32'h8,   0);
    applyStimulus("struct_x4_issue", 0, 0, 0, 0,  0, 0, 0, 0, 4,  1, 1, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("struct_after",    0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 1, 32'h10,  0);
    applyStimulus("wb_x4",           0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 4, RUN, RUN, 1, 32'h10,  0);
    applyStimulus("div_x9",          0, 0, 0, 0,  0, 0, 0, 0, 9,  1, 1, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("waw_x9",          0, 0, 0, 0,  0, 0, 0, 0, 9,  1, 0, 0, 0, STL, STL, 1, 32'h200, 0);
    applyStimulus("raw_rs2_x9",      0, 0, 0, 0,  0, 0, 9, 1, 0,  0, 0, 0, 0, STL, STL, 1, 32'h200, 0);
    applyStimulus("unused_src_x9",   0, 0, 0, 0,  9, 0, 9, 0, 0,  0, 0, 0, 0, RUN, RUN, 1, 32'h200, 0);
    applyStimulus("wb_x9",           0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 9, RUN, RUN, 1, 32'h200, 0);
    applyStimulus("idle_clean",      0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("err_wb",          0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 6, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("err_held",        0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   1);
    applyStimulus("br_kill",         0, 1, 0, 0,  0, 0, 0, 0, 10, 1, 1, 0, 0, BR,  BR,  0, 32'h0,   1);
    applyStimulus("br_kill_after",   0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   1);
    applyStimulus("div_x11",         0, 0, 0, 0,  0, 0, 0, 0, 11, 1, 1, 0, 0, RUN, RUN, 0, 32'h0,   1);
    applyStimulus("rst_mid",         1, 0, 1, 5,  5, 1, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 1, 32'h800, 1);
    applyStimulus("post_rst",        0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   0);
    applyStimulus("late_wb",         0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 11,RUN, RUN, 0, 32'h0,   0);
    applyStimulus("late_wb_err",     0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, RUN, RUN, 0, 32'h0,   1);

    for (int k = 0; k < 20 && expQ.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation pipeline hazard unit for the RV32IM 5-stage core. Sits between decode and execute and drives the PC, IF/ID and ID/EX enables and flushes.
- Adds the following over single-cycle combinational hazard detection:
  - a per-register scoreboard for multi-cycle (div/rem) results;
  - a counter that limits how many long-latency operations are in flight;
  - a programmable multi-cycle load-use stall.
- Branch redirect keeps the highest priority.

Parameters:
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7); set to 2 for 2-cycle data memory.
- MAX_INFLIGHT, 1, maximum long-latency ops outstanding at once (1..8).
- CNT_W, $clog2(MAX_INFLIGHT+1), width of the in-flight counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PCSrc  in  1  branch/jump taken, resolved in EX.
- MemRead_E  in  1  load in EX.
- rd_E  in  5  destination register of EX instruction.
- rs1_D, rs2_D  in  5 each  decode source registers.
- rs1_used_D, rs2_used_D  in  1 each  source is actually read (0 for lui/jal etc.).
- rd_D  in  5  decode destination register.
- RegWrite_D  in  1  decode instruction writes rd.
- is_long_D  in  1  decode instruction is a multi-cycle div/rem.
- lat_wb_valid  in  1  a long-latency op completes writeback this cycle.
- lat_wb_rd  in  5  its destination.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  zero IF/ID.
- IDEX_Flush  out  1  insert bubble into ID/EX.
- inflight_cnt  out  CNT_W  outstanding long ops.
- busy_vec  out  32  scoreboard; bit 0 is always 0.
- sb_err  out  1  sticky: completion arrived with inflight_cnt==0.

Behaviour:
- State: busy[31:1], inflight_cnt, ld_cnt (3 bits), sb_err.
- Reset (rst=1 at edge) clears all state to 0. While rst=1, outputs are PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0.
- Outputs are combinational from inputs and state, evaluated in the following priority order:
  1. Branch (PCSrc=1): PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1. ld_cnt is cleared at the next edge, abandoning any pending load stall. The decode instruction is killed, so nothing is issued.
  2. Load-use: active when ld_cnt!=0, or when a new hazard is detected. A new hazard is MemRead_E=1, rd_E!=0, and (rs1_used_D and rs1_D==rd_E, or rs2_used_D and rs2_D==rd_E).
     - A new detection loads ld_cnt with LOAD_STALL-1.
     - While ld_cnt!=0, it decrements by 1 per cycle.
     - Total stall is exactly LOAD_STALL cycles.
  3. Scoreboard RAW/WAW: stall when either of these holds:
     - (rs1_used_D and busy[rs1_D]) or (rs2_used_D and busy[rs2_D]);
     - RegWrite_D and busy[rd_D].
     The check reads registered busy with no bypass of a same-cycle lat_wb clear, so it costs one extra conservative cycle.
  4. Structural: stall when is_long_D=1 and inflight_cnt==MAX_INFLIGHT.
- Stall (cases 2–4): PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Flush=1.
- No hazard: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0.
- Issue: issue = is_long_D and no case 1–4 active.
  - On issue, inflight_cnt increments.
  - If also RegWrite_D and rd_D!=0, busy[rd_D] is set.
- Completion: lat_wb_valid clears busy[lat_wb_rd] and decrements inflight_cnt.
  - If inflight_cnt==0 at completion: the counter stays 0, busy is unchanged, and sb_err is set and held until rst.
- Simultaneous issue and completion: the count is unchanged. If both target the same register, the set wins. This case cannot legally occur because of the WAW stall.
- inflight_cnt saturates at MAX_INFLIGHT; never increments beyond it.
- Reset mid-stall or mid-divide clears everything. A divider completion after reset triggers the sb_err path.

Test Plan:
- Load-use, LOAD_STALL=2: MemRead_E=1, rd_E=5, rs1_D=5, rs1_used_D=1 → PC_Write=0 and IDEX_Flush=1 for exactly 2 cycles, then 1/0.
- Branch during load stall (LOAD_STALL=3): PCSrc=1 in the 2nd stall cycle → that cycle IFID_Flush=IDEX_Flush=1, PC_Write=1; next cycle no stall (ld_cnt=0).
- Scoreboard RAW: issue div to x7 → busy_vec[7]=1, inflight_cnt=1. Then add reading x7 → stall until the cycle after lat_wb_valid with lat_wb_rd=7; busy_vec[7]=0 afterwards.
- Structural, MAX_INFLIGHT=1: div to x3 outstanding, second div to x4 in decode → stalled. Completion of x3 → issues next cycle, inflight_cnt stays 1.
- x0 handling: load with rd_E=0 and rs1_D=0 → no stall. Div to x0 → inflight_cnt=1, busy_vec=0.
- Error and reset: lat_wb_valid=1 with inflight_cnt=0 → sb_err=1 and held. rst=1 for one cycle → sb_err=0, busy_vec=0, inflight_cnt=0.
